// File: rtl/hamming74_serial_encoder.sv
// Hamming(7,4) serial transmitter: buffers one nibble, encodes it on load and shifts
// the codeword out LSB first, followed by GAP_BITS guard slots at IDLE_LEVEL.
module hamming74_serial_encoder #(
    parameter int   GAP_BITS   = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       encode_out,
    output logic       frame_start,
    output logic       busy
);

    // state | meaning
    // IDLE  | line at IDLE_LEVEL, waiting for a pending nibble
    // SEND  | codeword bit b[slot] on encode_out
    // GAP   | guard slot number slot at IDLE_LEVEL
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    generate
        if (GAP_BITS < 0 || GAP_BITS > 7) begin : g_bad_gap
            $error("hamming74_serial_encoder: GAP_BITS must be in 0..7");
        end
    endgenerate

    localparam logic [2:0] GAP_LAST = (GAP_BITS > 0) ? 3'(GAP_BITS - 1) : 3'd0;

    state_t     state, state_nxt;
    logic [3:0] pend, pend_nxt;
    logic       pend_v, pend_v_nxt;
    logic [6:0] shifter, shifter_nxt;
    logic [2:0] slot, slot_nxt;
    logic       out_nxt;
    logic       fs_nxt;
    logic       load;
    logic       accept;
    logic [6:0] cw;

    function automatic logic [6:0] encode74(input logic [3:0] d);
        return {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[3],
                d[2] ^ d[1] ^ d[0], d[2], d[1], d[0]};
    endfunction

    // rst_n gates ready so nothing is accepted while reset is held
    assign data_ready = ena & ~pend_v & rst_n;
    assign accept     = data_valid & data_ready;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        pend_nxt    = pend;
        pend_v_nxt  = pend_v;
        shifter_nxt = shifter;
        slot_nxt    = slot;
        out_nxt     = encode_out;
        fs_nxt      = frame_start;
        load        = 1'b0;
        cw          = encode74(pend);
        if (ena) begin
            fs_nxt = 1'b0;
            if (accept) begin
                pend_nxt   = data_in;
                pend_v_nxt = 1'b1;
            end
            case (state)
                IDLE: begin
                    out_nxt = IDLE_LEVEL;
                    load    = pend_v;
                end
                SEND: begin
                    if (slot != 3'd6) begin
                        slot_nxt    = slot + 3'd1;
                        out_nxt     = shifter[0];
                        shifter_nxt = shifter >> 1;
                    end else if (GAP_BITS > 0) begin
                        state_nxt = GAP;
                        slot_nxt  = 3'd0;
                        out_nxt   = IDLE_LEVEL;
                    end else if (pend_v) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        slot_nxt  = 3'd0;
                        out_nxt   = IDLE_LEVEL;
                    end
                end
                GAP: begin
                    if (slot != GAP_LAST) begin
                        slot_nxt = slot + 3'd1;
                        out_nxt  = IDLE_LEVEL;
                    end else if (pend_v) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        slot_nxt  = 3'd0;
                        out_nxt   = IDLE_LEVEL;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    slot_nxt  = 3'd0;
                    out_nxt   = IDLE_LEVEL;
                end
            endcase
            // b0 goes straight to the line; the shifter keeps b1..b6
            if (load) begin
                shifter_nxt = {1'b0, cw[6:1]};
                out_nxt     = cw[0];
                fs_nxt      = 1'b1;
                pend_v_nxt  = 1'b0;
                slot_nxt    = 3'd0;
                state_nxt   = SEND;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pend        <= 4'd0;
            pend_v      <= 1'b0;
            shifter     <= 7'd0;
            slot        <= 3'd0;
            encode_out  <= IDLE_LEVEL;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            pend        <= pend_nxt;
            pend_v      <= pend_v_nxt;
            shifter     <= shifter_nxt;
            slot        <= slot_nxt;
            encode_out  <= out_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// Directed bench for hamming74_serial_encoder: default 1-slot-gap instance plus a
// GAP_BITS=0 instance for back-to-back streaming.
module tb_hamming74_serial_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] data_in;
    logic       data_valid;
    logic       data_ready, encode_out, frame_start, busy;
    logic [3:0] z_data;
    logic       z_valid;
    logic       z_ready, z_out, z_fs, z_busy;

    int n_chk  = 0;
    int n_fail = 0;

    // hand-computed codewords {b6..b0} for nibbles 0..15
    localparam logic [6:0] CW_TAB [16] = '{
        7'h00, 7'h69, 7'h2A, 7'h43, 7'h4C, 7'h25, 7'h66, 7'h0F,
        7'h70, 7'h19, 7'h5A, 7'h33, 7'h3C, 7'h55, 7'h16, 7'h7F
    };

    hamming74_serial_encoder dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready),
        .encode_out(encode_out), .frame_start(frame_start), .busy(busy)
    );

    hamming74_serial_encoder #(.GAP_BITS(0), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(z_data),
        .data_valid(z_valid), .data_ready(z_ready),
        .encode_out(z_out), .frame_start(z_fs), .busy(z_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // receive-side Hamming(7,4) single-error-correcting decoder
    function automatic logic [3:0] decode74(input logic [6:0] w);
        logic [6:0] b;
        logic [2:0] syn;
        b   = w;
        syn = {b[0] ^ b[2] ^ b[4] ^ b[6], b[0] ^ b[1] ^ b[4] ^ b[5], b[0] ^ b[1] ^ b[2] ^ b[3]};
        case (syn)
            3'b111: b[0] = ~b[0];
            3'b011: b[1] = ~b[1];
            3'b101: b[2] = ~b[2];
            3'b001: b[3] = ~b[3];
            3'b110: b[4] = ~b[4];
            3'b010: b[5] = ~b[5];
            3'b100: b[6] = ~b[6];
            default: ;
        endcase
        return {b[4], b[2], b[1], b[0]};
    endfunction

    task automatic send_capture(input logic [3:0] n);
        int t;
        logic [6:0] w;
        logic [6:0] exp_w;
        t = 0;
        while (!data_ready && t < 30) begin tick(); t++; end
        check("t6_ready_wait", 32'(t < 30), 1);
        data_in    = n;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        t = 0;
        while (!frame_start && t < 30) begin tick(); t++; end
        check("t6_start_wait", 32'(t < 30), 1);
        w = 7'd0;
        for (int i = 0; i < 7; i++) begin
            w[i] = encode_out;
            if (i < 6) tick();
        end
        exp_w = CW_TAB[n];
        check($sformatf("t6_word_%0d", n), 32'(w), 32'(exp_w));
        check($sformatf("t6_decode_%0d", n), 32'(decode74(w)), 32'(n));
    endtask

    initial begin
        logic [6:0] w1, w2;
        logic       eb, er;
        int         bad;

        rst_n = 1'b0; ena = 1'b1; data_in = 4'd0; data_valid = 1'b0;
        z_data = 4'd0; z_valid = 1'b0;
        #12;
        check("rst_out", 32'(encode_out), 0);
        check("rst_fs", 32'(frame_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(data_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_rel_ready", 32'(data_ready), 1);

        // 1: single frame 1011
        w1 = CW_TAB[11];
        data_in = 4'b1011; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check("t1_ready_pend", 32'(data_ready), 0);
        check("t1_idle_out", 32'(encode_out), 0);
        check("t1_idle_busy", 32'(busy), 0);
        tick();
        check("t1_fs", 32'(frame_start), 1);
        check("t1_busy", 32'(busy), 1);
        check("t1_b0", 32'(encode_out), 32'(w1[0]));
        for (int i = 1; i < 7; i++) begin
            tick();
            check($sformatf("t1_b%0d", i), 32'(encode_out), 32'(w1[i]));
            check($sformatf("t1_fs_b%0d", i), 32'(frame_start), 0);
        end
        tick();
        check("t1_gap_out", 32'(encode_out), 0);
        check("t1_gap_busy", 32'(busy), 1);
        tick();
        check("t1_end_busy", 32'(busy), 0);

        // 2: 0000 then 1111 back to back
        data_in = 4'b0000; data_valid = 1'b1;
        tick();
        check("t2_ready_full", 32'(data_ready), 0);
        data_in = 4'b1111;
        tick();
        for (int i = 0; i < 16; i++) begin
            eb = (i >= 8 && i < 15);
            er = (i == 0 || i >= 8);
            check($sformatf("t2_bit%0d", i), 32'(encode_out), 32'(eb));
            check($sformatf("t2_ready%0d", i), 32'(data_ready), 32'(er));
            if (i == 8) check("t2_fs2", 32'(frame_start), 1);
            tick();
            if (i == 0) data_valid = 1'b0;
        end
        check("t2_end_busy", 32'(busy), 0);

        // 3: GAP_BITS=0 streaming 0101 then 1010
        w1 = CW_TAB[5];
        w2 = CW_TAB[10];
        z_data = 4'b0101; z_valid = 1'b1;
        tick();
        z_data = 4'b1010;
        tick();
        for (int i = 0; i < 14; i++) begin
            eb = (i < 7) ? w1[i] : w2[i-7];
            check($sformatf("t3_bit%0d", i), 32'(z_out), 32'(eb));
            check($sformatf("t3_busy%0d", i), 32'(z_busy), 1);
            if (i == 0 || i == 7) check($sformatf("t3_fs%0d", i), 32'(z_fs), 1);
            tick();
            if (i == 0) z_valid = 1'b0;
        end
        check("t3_end_busy", 32'(z_busy), 0);
        check("t3_end_out", 32'(z_out), 0);

        // 4: ena low for 3 cycles at slot 3 of 1011
        w1 = CW_TAB[11];
        data_in = 4'b1011; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("t4_b3", 32'(encode_out), 32'(w1[3]));
        ena = 1'b0; data_valid = 1'b1; data_in = 4'b0110;
        #1;
        check("t4_ready_off", 32'(data_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t4_frozen%0d", i), 32'(encode_out), 32'(w1[3]));
            check($sformatf("t4_busy%0d", i), 32'(busy), 1);
            check($sformatf("t4_ready%0d", i), 32'(data_ready), 0);
        end
        data_valid = 1'b0; ena = 1'b1;
        for (int i = 4; i < 7; i++) begin
            tick();
            check($sformatf("t4_b%0d", i), 32'(encode_out), 32'(w1[i]));
        end
        tick();
        check("t4_gap", 32'(encode_out), 0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy || encode_out) bad++;
        end
        check("t4_no_extra_frame", 32'(bad), 0);

        // 5: reset at slot 4 with a nibble pending
        data_in = 4'b1011; data_valid = 1'b1;
        tick();
        data_in = 4'b0110;
        tick();
        tick();
        data_valid = 1'b0;
        check("t5_pending", 32'(data_ready), 0);
        tick(); tick(); tick();
        check("t5_b4", 32'(encode_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out", 32'(encode_out), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_fs", 32'(frame_start), 0);
        check("t5_rst_ready", 32'(data_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy || encode_out || frame_start) bad++;
        end
        check("t5_silent", 32'(bad), 0);

        // 6: loopback all nibbles
        for (int n = 0; n < 16; n++) send_capture(4'(n));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
